// File: rtl/alu_checker.sv
// Two-stage ALU result checker: recomputes the expected result, compares it with f one cycle later, and keeps counts.
// Optional macro ALU_CHK_FIRST_EN adds capture of the first mismatching transaction.
module alu_checker #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [2:0]        aluop,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] f,
   input  logic              clear,
   output logic [CNT_W-1:0]  chk_count,
   output logic [CNT_W-1:0]  err_count,
   output logic              err
`ifdef ALU_CHK_FIRST_EN
   ,
   output logic [2:0]        first_op,
   output logic [DATA_W-1:0] first_exp,
   output logic [DATA_W-1:0] first_got
`endif
);

   localparam int SH_W = $clog2(DATA_W);

   function automatic logic [DATA_W-1:0] alu_ref(input logic [2:0]        op,
                                                 input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] y);
      logic signed [DATA_W-1:0] xs;
      logic [SH_W-1:0]          sh;
      xs = x;
      sh = y[SH_W-1:0];
      case (op)
         3'd0:    alu_ref = x + y;
         3'd1:    alu_ref = x - y;
         3'd2:    alu_ref = x << sh;
         3'd3:    alu_ref = x >> sh;
         3'd4:    alu_ref = xs >>> sh;
         3'd5:    alu_ref = x & y;
         3'd6:    alu_ref = x | y;
         default: alu_ref = x ^ y;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      sat_inc = (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
   endfunction

   logic [DATA_W-1:0] exp_p0;
   logic [2:0]        op_p1;
   logic [DATA_W-1:0] exp_p1;
   logic [DATA_W-1:0] f_p1;
   logic              vld_p1;
   logic              mis_p1;

   // Stage 0 -> 1: expected value, registered only for valid transactions
   always_comb begin
      exp_p0 = alu_ref(aluop, a, b);
   end

   always_ff @(posedge clk) begin
      if (in_valid) begin
         op_p1  <= aluop;
         exp_p1 <= alu_ref(aluop, a, b);
         f_p1   <= f;
      end
   end

   // Stage 1 -> 2: compare; an unknown compare result falls into the mismatch branch
   always_comb begin
      mis_p1 = 1'b1;
      if (f_p1 == exp_p1) mis_p1 = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1    <= 1'b0;
         chk_count <= '0;
         err_count <= '0;
         err       <= 1'b0;
`ifdef ALU_CHK_FIRST_EN
         first_op  <= '0;
         first_exp <= '0;
         first_got <= '0;
`endif
      end else if (clear) begin
         vld_p1    <= 1'b0;
         chk_count <= '0;
         err_count <= '0;
         err       <= 1'b0;
`ifdef ALU_CHK_FIRST_EN
         first_op  <= '0;
         first_exp <= '0;
         first_got <= '0;
`endif
      end else begin
         vld_p1 <= in_valid;
         if (vld_p1) begin
            chk_count <= sat_inc(chk_count);
            if (mis_p1) begin
               err_count <= sat_inc(err_count);
               err       <= 1'b1;
`ifdef ALU_CHK_FIRST_EN
               if (!err) begin
                  first_op  <= op_p1;
                  first_exp <= exp_p1;
                  first_got <= f_p1;
               end
`endif
            end
         end
      end
   end

   logic unused_exp;
   assign unused_exp = ^exp_p0;

endmodule

// File: tb/tb_alu_checker.sv
// Self-checking bench for alu_checker: directed scenarios plus random traffic against a queue-based reference model.
module tb_alu_checker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [2:0]  aluop;
   logic [31:0] a, b, f;
   logic        clear;
   logic [15:0] chk_count, err_count;
   logic        err;
`ifdef ALU_CHK_FIRST_EN
   logic [2:0]  first_op;
   logic [31:0] first_exp, first_got;
`endif

   always #5 clk = ~clk;

   alu_checker dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .aluop     (aluop),
      .a         (a),
      .b         (b),
      .f         (f),
      .clear     (clear),
      .chk_count (chk_count),
      .err_count (err_count),
      .err       (err)
`ifdef ALU_CHK_FIRST_EN
      ,
      .first_op  (first_op),
      .first_exp (first_exp),
      .first_got (first_got)
`endif
   );

   typedef struct {
      bit          mis;
      logic [2:0]  op;
      logic [31:0] exp;
      logic [31:0] got;
   } txn_t;

   int          n_checks = 0;
   int          n_errors = 0;
   int          m_chk, m_err;
   bit          m_flag;
   logic [2:0]  m_fop;
   logic [31:0] m_fexp, m_fgot;
   txn_t        q[$];

   function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
      int unsigned sh;
      sh = y % 32;
      case (op)
         3'd0: return x + y;
         3'd1: return x - y;
         3'd2: return x << sh;
         3'd3: return x >> sh;
         3'd4: return (x >> sh) | (x[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
         3'd5: return x & y;
         3'd6: return x | y;
         default: return x ^ y;
      endcase
   endfunction

   task automatic model_reset();
      m_chk = 0; m_err = 0; m_flag = 0;
      m_fop = '0; m_fexp = '0; m_fgot = '0;
      q.delete();
   endtask

   task automatic model_edge(input bit v, input bit clr, input logic [2:0] op,
                             input logic [31:0] x, input logic [31:0] y, input logic [31:0] r);
      txn_t t;
      if (clr) begin
         model_reset();
      end else begin
         if (q.size() > 0) begin
            t = q.pop_front();
            if (m_chk < 65535) m_chk++;
            if (t.mis) begin
               if (m_err < 65535) m_err++;
               if (!m_flag) begin
                  m_fop = t.op; m_fexp = t.exp; m_fgot = t.got;
               end
               m_flag = 1;
            end
         end
         if (v) begin
            t.op  = op;
            t.exp = ref_alu(op, x, y);
            t.got = r;
            t.mis = (r !== t.exp);
            q.push_back(t);
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_checks++;
      assert (got === expv) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, expv);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".chk"}, {16'h0, chk_count}, m_chk);
      check({tag, ".errc"}, {16'h0, err_count}, m_err);
      check({tag, ".err"}, {31'h0, err}, {31'h0, m_flag});
`ifdef ALU_CHK_FIRST_EN
      check({tag, ".fop"}, {29'h0, first_op}, {29'h0, m_fop});
      check({tag, ".fexp"}, first_exp, m_fexp);
      check({tag, ".fgot"}, first_got, m_fgot);
`endif
   endtask

   task automatic step(input bit v, input bit clr, input logic [2:0] op, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] r, input bit do_chk, input string tag);
      in_valid = v; clear = clr; aluop = op; a = x; b = y; f = r;
      @(posedge clk);
      model_edge(v, clr, op, x, y, r);
      #1;
      if (do_chk) check_all(tag);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b1, tag);
   endtask

   task automatic pulse_reset(input string tag);
      #2;
      rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [31:0] sweep_f [8];

   initial begin
      logic [2:0]  op;
      logic [31:0] x, y, r;
      bit          v, clr;

      sweep_f = '{32'h800055AE, 32'h800055A6, 32'h00055AA0, 32'h0800055A,
                  32'hF800055A, 32'h00000000, 32'h800055AE, 32'h800055AE};
      rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0;
      aluop = '0; a = '0; b = '0; f = '0;
      model_reset();
      #2;
      check_all("reset");
      #5;
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++)
         step(1'b1, 1'b0, 3'(i), 32'h800055AA, 32'h4, sweep_f[i], 1'b1, "sweep");
      idle(2, "sweep_drain");
      check("sweep_chk8", {16'h0, chk_count}, 32'd8);
      check("sweep_err0", {31'h0, err}, 32'd0);

      step(1'b1, 1'b0, 3'd2, 32'h1, 32'h21, 32'h4, 1'b1, "mism");
      idle(2, "mism_drain");
      check("mism_err", {31'h0, err}, 32'd1);
      check("mism_errc", {16'h0, err_count}, 32'd1);
`ifdef ALU_CHK_FIRST_EN
      check("mism_fop", {29'h0, first_op}, 32'd2);
      check("mism_fexp", first_exp, 32'h2);
      check("mism_fgot", first_got, 32'h4);
`endif

      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 'x, 'x, 'x, 'x, 1'b1, "idle_x");
      check("idlex_chk", {16'h0, chk_count}, 32'd9);
      check("idlex_errc", {16'h0, err_count}, 32'd1);

      step(1'b0, 1'b1, 3'd0, 32'h0, 32'h0, 32'h0, 1'b1, "clr0");
      for (int i = 0; i < 300; i++) begin
         v   = ($urandom % 4) != 0;
         clr = ($urandom % 40) == 0;
         op  = 3'($urandom % 8);
         x   = $urandom;
         y   = ($urandom % 2 == 0) ? 32'($urandom % 64) : $urandom;
         r   = ref_alu(op, x, y);
         if ($urandom % 4 == 0) r = r ^ (32'h1 << ($urandom % 32));
         step(v, clr, op, x, y, r, 1'b1, "rand");
      end

      step(1'b1, 1'b0, 3'd0, 32'h1, 32'h1, 32'h2, 1'b1, "coll_pre");
      step(1'b1, 1'b1, 3'd0, 32'h1, 32'h1, 32'h5, 1'b1, "coll");
      idle(2, "coll_drain");
      check("coll_chk", {16'h0, chk_count}, 32'd0);
      check("coll_errc", {16'h0, err_count}, 32'd0);
      check("coll_err", {31'h0, err}, 32'd0);

      step(1'b1, 1'b0, 3'd0, 32'h5, 32'h6, 32'hB, 1'b1, "ar_a");
      step(1'b1, 1'b0, 3'd0, 32'h5, 32'h6, 32'h0, 1'b1, "ar_b");
      step(1'b1, 1'b0, 3'd0, 32'h5, 32'h6, 32'hB, 1'b1, "ar_c");
      pulse_reset("async_rst");
      idle(2, "ar_after");
      check("ar_chk", {16'h0, chk_count}, 32'd0);
      check("ar_err", {31'h0, err}, 32'd0);

      for (int i = 0; i < 65540; i++) begin
         op = 3'($urandom % 8);
         x  = $urandom;
         y  = $urandom;
         step(1'b1, 1'b0, op, x, y, ref_alu(op, x, y), 1'b0, "sat");
      end
      idle(2, "sat_drain");
      check("sat_chk", {16'h0, chk_count}, 32'h0000FFFF);
      check("sat_errc", {16'h0, err_count}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_checker.md
ALU_CHECKER -- requirements
Module: alu_checker

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-low reset.
REQ-002 Port `clk`, input, 1 bit: the sole clock; all state changes on its rising edge.
REQ-003 Port `rst_n`, input, 1 bit: asynchronous active-low reset.
REQ-004 Port `in_valid`, input, 1 bit: the operands, op and result are a transaction to check this cycle.
REQ-005 Port `aluop`, input, 3 bits: the ALU operation applied to `a`/`b`.
REQ-006 Ports `a` and `b`, input, 32 bits each: the ALU operands.
REQ-007 Port `f`, input, 32 bits: the ALU result, valid in the same cycle as its operands.
REQ-008 Port `clear`, input, 1 bit: synchronous clear of the counters, error flag and in-flight transaction.
REQ-009 Port `chk_count`, output, 16 bits: number of transactions checked.
REQ-010 Port `err_count`, output, 16 bits: number of mismatches.
REQ-011 Port `err`, output, 1 bit: sticky mismatch flag.
REQ-012 Ports `first_op` (3 bits), `first_exp` (32 bits) and `first_got` (32 bits), outputs: capture of the first mismatch; present only under ALU_CHK_FIRST_EN.

Function
REQ-013 The expected result SHALL be: 0 add a+b; 1 sub a-b; 2 sll a<<b[4:0]; 3 srl logical a>>b[4:0]; 4 sra arithmetic a>>>b[4:0]; 5 a&b; 6 a|b; 7 a^b.
REQ-014 Add and sub SHALL wrap modulo 2^32, with no carry or overflow reported.
REQ-015 Stage 1: on a rising edge with in_valid=1, the block SHALL register aluop, f and the expected value, and set the stage-1 valid bit.
REQ-016 Stage 2: on the next rising edge, if the stage-1 valid bit is set, the block SHALL compare the registered f with the expected value.
REQ-017 Outputs SHALL reflect a transaction after the second rising edge following its sampling (latency 2), with a throughput of one transaction per cycle.
REQ-018 When in_valid=0, a, b, aluop and f SHALL be ignored, and X/Z on them SHALL have no effect.
REQ-019 An f carrying any X/Z bit while in_valid=1 SHALL count as a mismatch (simulation semantics).
REQ-020 Each compared transaction SHALL increment chk_count; each mismatch SHALL increment err_count and set err.
REQ-021 Both counters SHALL saturate at 0xFFFF and never wrap.
REQ-022 err SHALL remain 1 until reset or clear.
REQ-023 When clear=1 at an edge, the block SHALL zero chk_count, err_count and err and drop the stage-1 valid bit; an in_valid transaction on the same edge SHALL be discarded.
REQ-024 When clear=0, a new transaction SHALL be sampled on the same edge an older transaction is compared, with no bubble.
REQ-025 Reset asserted mid-operation SHALL discard any in-flight transaction immediately.

Reset
REQ-026 While rst_n=0, chk_count=0, err_count=0, err=0 and the stage-1 valid bit = 0, independent of clk.
REQ-027 While rst_n=0 and ALU_CHK_FIRST_EN is defined, first_op=0, first_exp=0 and first_got=0.
REQ-028 The first edge after rst_n rises SHALL be able to sample a transaction.

Configuration
REQ-029 Macro ALU_CHK_FIRST_EN defined: on the mismatch that takes err from 0 to 1, first_op/first_exp/first_got SHALL capture aluop, the expected value and f.
REQ-030 Under ALU_CHK_FIRST_EN, the first_* registers SHALL hold their value until reset or clear, and clear SHALL zero them.
REQ-031 Macro ALU_CHK_FIRST_EN undefined: the first_* ports and registers SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Sweep: a=0x800055AA, b=0x4, aluop 0..7 on consecutive cycles, with f = 0x800055AE, 0x800055A6, 0x00055AA0, 0x0800055A, 0xF800055A, 0x00000000, 0x800055AE, 0x800055AE -> chk_count=8, err_count=0, err=0 two cycles after the last op.
REQ-033 Mismatch: aluop=2, a=1, b=0x21, f=0x4 (expected 0x2) -> err=1 and err_count=1 two edges later; under ALU_CHK_FIRST_EN first_op=2, first_exp=0x2, first_got=0x4.
REQ-034 Idle X: in_valid=0 with a, b, aluop and f all X for 5 cycles -> counts unchanged and err=0.
REQ-035 Saturation: 65540 valid correct transactions -> chk_count=0xFFFF.
REQ-036 Clear collision: a valid mismatching transaction with clear=1 on the same edge -> err=0 and both counts 0 afterwards.
REQ-037 Async reset: rst_n pulled low mid-cycle with a transaction in flight -> outputs 0 before the next edge, and no count once rst_n is released.
